// File: rtl/march_ctrl.sv
// March C- BIST sequencer: steers adr_gen through the six march elements,
// strobes a single-port memory and checks read data against the background.
module march_ctrl #(
    parameter int unsigned ADR_SIZE   = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADR_SIZE-1:0]   adress,
    input  logic                  adr_c_out,
    output logic                  adr_rst,
    output logic                  adr_pr_res,
    output logic                  adr_en,
    output logic                  adr_up_down,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADR_SIZE-1:0]   fail_adr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD,
        S_WR,
        S_CMP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  last_q, last_d;
    logic                  fail_q, fail_d;
    logic [ADR_SIZE-1:0]   fail_adr_q, fail_adr_d;

    logic                  elem_up;
    logic                  exp_bit;
    logic                  wr_bit;
    logic                  last;
    logic                  mismatch;

    // M3/M4 walk downwards; M2/M4 expect ones; M1/M3 write ones.
    assign elem_up  = (elem_q != 3'd3) && (elem_q != 3'd4);
    assign exp_bit  = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign wr_bit   = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign mismatch = (mem_rdata != {DATA_WIDTH{exp_bit}});
    // adr_c_out may only be high in the first cycle at the final address.
    assign last     = adr_c_out | last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            elem_q     <= '0;
            last_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_adr_q <= '0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            last_q     <= last_d;
            fail_q     <= fail_d;
            fail_adr_q <= fail_adr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        last_d      = last_q | adr_c_out;
        fail_d      = fail_q;
        fail_adr_d  = fail_adr_q;
        adr_rst     = 1'b0;
        adr_pr_res  = 1'b0;
        adr_en      = 1'b0;
        adr_up_down = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_SETUP;
                    elem_d     = '0;
                    fail_d     = 1'b0;
                    fail_adr_d = '0;
                end
            end
            S_SETUP: begin
                adr_up_down = elem_up;
                adr_rst     = elem_up;
                adr_pr_res  = ~elem_up;
                last_d      = 1'b0;
                state_d     = (elem_q == 3'd0) ? S_WR : S_RD;
            end
            S_RD: begin
                adr_up_down = elem_up;
                mem_re      = 1'b1;
                state_d     = (elem_q == 3'd5) ? S_CMP : S_WR;
            end
            S_WR, S_CMP: begin
                adr_up_down = elem_up;
                // A mismatch aborts in place: no write, no address step.
                if ((elem_q != 3'd0) && mismatch) begin
                    fail_d     = 1'b1;
                    fail_adr_d = adress;
                    state_d    = S_DONE;
                end else begin
                    if (state_q == S_WR) begin
                        mem_we    = 1'b1;
                        mem_wdata = {DATA_WIDTH{wr_bit}};
                    end
                    if (!last) begin
                        adr_en  = 1'b1;
                        state_d = (elem_q == 3'd0) ? S_WR : S_RD;
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        elem_d  = elem_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_SETUP) || (state_q == S_RD) ||
                      (state_q == S_WR)    || (state_q == S_CMP);
    assign done     = (state_q == S_DONE);
    assign fail     = fail_q;
    assign fail_adr = fail_adr_q;

endmodule

// File: tb/tb_march_ctrl.sv
// Directed bench for march_ctrl: behavioural adr_gen and memory models around
// a 16-word and a 4-word instance.
module tb_march_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    logic       a_start, a_c_out, a_adr_rst, a_pr_res, a_en, a_up, a_re, a_we;
    logic       a_busy, a_done, a_fail, fault_a;
    logic [3:0] a_adress, a_fail_adr;
    logic [7:0] a_wdata, a_rdata;
    logic [7:0] mem_a [16];

    logic       b_start, b_c_out, b_adr_rst, b_pr_res, b_en, b_up, b_re, b_we;
    logic       b_busy, b_done, b_fail;
    logic [1:0] b_adress, b_fail_adr;
    logic [7:0] b_wdata, b_rdata;
    logic [7:0] mem_b [4];

    march_ctrl #(.ADR_SIZE(4), .DATA_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .adress(a_adress),
        .adr_c_out(a_c_out), .adr_rst(a_adr_rst), .adr_pr_res(a_pr_res),
        .adr_en(a_en), .adr_up_down(a_up), .mem_re(a_re), .mem_we(a_we),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata), .busy(a_busy),
        .done(a_done), .fail(a_fail), .fail_adr(a_fail_adr)
    );

    march_ctrl #(.ADR_SIZE(2), .DATA_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .adress(b_adress),
        .adr_c_out(b_c_out), .adr_rst(b_adr_rst), .adr_pr_res(b_pr_res),
        .adr_en(b_en), .adr_up_down(b_up), .mem_re(b_re), .mem_we(b_we),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata), .busy(b_busy),
        .done(b_done), .fail(b_fail), .fail_adr(b_fail_adr)
    );

    // adr_gen models: carry-out high only in the first cycle at the end address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_adress <= '0; a_c_out <= 1'b0;
        end else if (a_adr_rst) begin
            a_adress <= '0; a_c_out <= 1'b0;
        end else if (a_pr_res) begin
            a_adress <= '1; a_c_out <= 1'b0;
        end else if (a_en) begin
            a_adress <= a_up ? a_adress + 4'd1 : a_adress - 4'd1;
            a_c_out  <= a_up ? (a_adress == 4'd14) : (a_adress == 4'd1);
        end else begin
            a_c_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_adress <= '0; b_c_out <= 1'b0;
        end else if (b_adr_rst) begin
            b_adress <= '0; b_c_out <= 1'b0;
        end else if (b_pr_res) begin
            b_adress <= '1; b_c_out <= 1'b0;
        end else if (b_en) begin
            b_adress <= b_up ? b_adress + 2'd1 : b_adress - 2'd1;
            b_c_out  <= b_up ? (b_adress == 2'd2) : (b_adress == 2'd1);
        end else begin
            b_c_out <= 1'b0;
        end
    end

    // Memories; fault_a models bit 3 of address 5 stuck at 0.
    always @(posedge clk) begin
        if (a_we) mem_a[a_adress] <= a_wdata;
        if (a_re) a_rdata <= mem_a[a_adress] & ((fault_a && a_adress == 4'd5) ? 8'hF7 : 8'hFF);
        if (b_we) mem_b[b_adress] <= b_wdata;
        if (b_re) b_rdata <= mem_b[b_adress];
    end

    int         a_wcnt = 0, a_rcnt = 0, a_rstp = 0, a_prp = 0, a_viol = 0, a_enviol = 0;
    int         b_wcnt = 0, b_rcnt = 0, b_viol = 0;
    logic [11:0] a_wptr = '0, a_rptr = '0;
    logic [3:0]  a_wlog [4096];
    logic [3:0]  a_rlog [4096];

    always @(posedge clk) begin
        if (a_we) begin a_wlog[a_wptr] <= a_adress; a_wptr <= a_wptr + 12'd1; a_wcnt <= a_wcnt + 1; end
        if (a_re) begin a_rlog[a_rptr] <= a_adress; a_rptr <= a_rptr + 12'd1; a_rcnt <= a_rcnt + 1; end
        if (a_adr_rst) a_rstp <= a_rstp + 1;
        if (a_pr_res)  a_prp  <= a_prp + 1;
        if ((a_re && a_we) || (a_adr_rst && a_pr_res)) a_viol <= a_viol + 1;
        if (a_en && ((a_up && a_adress == 4'hF) || (!a_up && a_adress == 4'h0))) a_enviol <= a_enviol + 1;
        if (b_we) b_wcnt <= b_wcnt + 1;
        if (b_re) b_rcnt <= b_rcnt + 1;
        if ((b_re && b_we) || (b_adr_rst && b_pr_res) ||
            (b_en && ((b_up && b_adress == 2'd3) || (!b_up && b_adress == 2'd0)))) b_viol <= b_viol + 1;
    end

    function automatic logic [20:0] a_outs();
        return {a_adr_rst, a_pr_res, a_en, a_up, a_re, a_we, a_wdata,
                a_busy, a_done, a_fail, a_fail_adr};
    endfunction

    function automatic logic [18:0] b_outs();
        return {b_adr_rst, b_pr_res, b_en, b_up, b_re, b_we, b_wdata,
                b_busy, b_done, b_fail, b_fail_adr};
    endfunction

    task automatic wait_done_a(output int edges);
        edges = 0;
        while (a_done !== 1'b1 && edges < 1000) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic pulse_a();
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (a_outs() !== 21'd0) begin n_fail++; $display("FAIL reset_a_outs: got %h exp 0", a_outs()); end
        n_checks++;
        if (b_outs() !== 19'd0) begin n_fail++; $display("FAIL reset_b_outs: got %h exp 0", b_outs()); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_busy, a_done} !== 2'b00) begin n_fail++; $display("FAIL idle_no_start: busy/done %b exp 00", {a_busy, a_done}); end
    endtask

    task automatic test_clean_run();
        int w0, r0, rp0, pp0, v0, e0, edges, werr, rerr, nz;
        logic [11:0] wp0, rp_0;
        logic [3:0]  ea;
        w0 = a_wcnt; r0 = a_rcnt; rp0 = a_rstp; pp0 = a_prp; v0 = a_viol; e0 = a_enviol;
        wp0 = a_wptr; rp_0 = a_rptr;
        pulse_a();
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b exp 1", a_busy); end
        wait_done_a(edges);
        n_checks++;
        if (edges != 182) begin n_fail++; $display("FAIL clean_done_edges: got %0d exp 182", edges); end
        n_checks++;
        if (a_fail !== 1'b0) begin n_fail++; $display("FAIL clean_fail: got %b exp 0", a_fail); end
        n_checks++;
        if (a_wcnt - w0 != 80) begin n_fail++; $display("FAIL clean_writes: got %0d exp 80", a_wcnt - w0); end
        n_checks++;
        if (a_rcnt - r0 != 80) begin n_fail++; $display("FAIL clean_reads: got %0d exp 80", a_rcnt - r0); end
        n_checks++;
        if (a_rstp - rp0 != 4 || a_prp - pp0 != 2) begin
            n_fail++; $display("FAIL adr_load_pulses: rst %0d pr %0d exp 4 2", a_rstp - rp0, a_prp - pp0);
        end
        n_checks++;
        if (a_viol - v0 != 0 || a_enviol - e0 != 0) begin
            n_fail++; $display("FAIL strobe_rules: excl %0d en_at_end %0d exp 0 0", a_viol - v0, a_enviol - e0);
        end
        werr = 0; rerr = 0;
        for (int k = 0; k < 80; k++) begin
            ea = (k / 16 < 3) ? 4'(k % 16) : 4'(15 - k % 16);
            if (a_wlog[wp0 + 12'(k)] !== ea) werr++;
            ea = (k / 16 == 2 || k / 16 == 3) ? 4'(15 - k % 16) : 4'(k % 16);
            if (a_rlog[rp_0 + 12'(k)] !== ea) rerr++;
        end
        n_checks++;
        if (werr != 0) begin n_fail++; $display("FAIL write_order: %0d wrong addresses exp 0", werr); end
        n_checks++;
        if (rerr != 0) begin n_fail++; $display("FAIL read_order: %0d wrong addresses exp 0", rerr); end
        nz = 0;
        for (int i = 0; i < 16; i++) if (mem_a[i] !== 8'h00) nz++;
        n_checks++;
        if (nz != 0) begin n_fail++; $display("FAIL final_mem_zero: %0d nonzero words exp 0", nz); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_busy, a_done} !== 2'b01) begin n_fail++; $display("FAIL done_held: busy/done %b exp 01", {a_busy, a_done}); end
    endtask

    task automatic test_stuck_fault();
        int w0, r0, w1, r1, edges;
        fault_a = 1'b1;
        w0 = a_wcnt; r0 = a_rcnt;
        pulse_a();
        wait_done_a(edges);
        n_checks++;
        if (edges != 63) begin n_fail++; $display("FAIL fault_done_edges: got %0d exp 63", edges); end
        n_checks++;
        if (a_fail !== 1'b1 || a_fail_adr !== 4'd5) begin
            n_fail++; $display("FAIL fault_report: fail %b adr %0d exp 1 5", a_fail, a_fail_adr);
        end
        n_checks++;
        if (a_wcnt - w0 != 37 || a_rcnt - r0 != 22) begin
            n_fail++; $display("FAIL fault_accesses: wr %0d rd %0d exp 37 22", a_wcnt - w0, a_rcnt - r0);
        end
        w1 = a_wcnt; r1 = a_rcnt;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (a_wcnt != w1 || a_rcnt != r1 || a_done !== 1'b1) begin
            n_fail++; $display("FAIL fault_quiet: wr+%0d rd+%0d done %b exp 0 0 1", a_wcnt - w1, a_rcnt - r1, a_done);
        end
    endtask

    task automatic test_restart_hold();
        int edges;
        fault_a = 1'b0;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({a_busy, a_done, a_fail, a_fail_adr} !== 7'b1000000) begin
            n_fail++; $display("FAIL restart_clears: busy/done/fail/adr %b exp 1000000", {a_busy, a_done, a_fail, a_fail_adr});
        end
        wait_done_a(edges);
        n_checks++;
        if (edges != 182 || a_fail !== 1'b0) begin
            n_fail++; $display("FAIL hold_run: edges %0d fail %b exp 182 0", edges, a_fail);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({a_busy, a_done} !== 2'b10) begin n_fail++; $display("FAIL hold_restart: busy/done %b exp 10", {a_busy, a_done}); end
        a_start = 1'b0;
        wait_done_a(edges);
        n_checks++;
        if (edges != 182 || a_fail !== 1'b0) begin
            n_fail++; $display("FAIL second_run: edges %0d fail %b exp 182 0", edges, a_fail);
        end
    endtask

    task automatic test_async_reset();
        int edges, w0;
        pulse_a();
        repeat (60) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        n_checks++;
        if (a_outs() !== 21'd0) begin n_fail++; $display("FAIL async_reset_outs: got %h exp 0", a_outs()); end
        @(negedge clk); rst = 1'b0;
        w0 = a_wcnt;
        pulse_a();
        wait_done_a(edges);
        n_checks++;
        if (edges != 182 || a_fail !== 1'b0 || a_wcnt - w0 != 80) begin
            n_fail++; $display("FAIL post_reset_run: edges %0d fail %b wr %0d exp 182 0 80", edges, a_fail, a_wcnt - w0);
        end
    endtask

    task automatic test_min_depth();
        int edges, w0, r0, v0;
        w0 = b_wcnt; r0 = b_rcnt; v0 = b_viol;
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        edges = 0;
        while (b_done !== 1'b1 && edges < 300) begin
            @(posedge clk); #1; edges++;
        end
        n_checks++;
        if (edges != 50) begin n_fail++; $display("FAIL min_done_edges: got %0d exp 50", edges); end
        n_checks++;
        if (b_fail !== 1'b0 || b_wcnt - w0 != 20 || b_rcnt - r0 != 20 || b_viol != v0) begin
            n_fail++; $display("FAIL min_run: fail %b wr %0d rd %0d viol %0d exp 0 20 20 0",
                               b_fail, b_wcnt - w0, b_rcnt - r0, b_viol - v0);
        end
    endtask

    initial begin
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; fault_a = 1'b0;
        test_reset();
        test_clean_run();
        test_stuck_fault();
        test_restart_hold();
        test_async_reset();
        test_min_depth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
